pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  - Parametrised, elastic successor to the fixed-field inter-stage pipeline registers.
//  - Carries an opaque WIDTH-bit payload; each pipeline stage packs its struct into it.
//  - Uses a valid/ready handshake with a 2-entry skid buffer, so throughput is 1/cycle.
//  - in_ready is driven only from state, so the stall path is cut at every stage.
//  - Adds a flush (squash) input and, optionally, stall/flush performance counters.
// PARAMETERS
//  WIDTH     32  payload width in bits (>=1)
//  RESET_VAL '0  payload value driven on out_data after reset and after flush
//  CNT_W     32  perf counter width (used only with PIPE_STAGE_PERF_EN)
// PORTS
//  clk           in   1      clock; all state updates on its rising edge
//  rst_n         in   1      reset; synchronous, active-low
//  flush         in   1      squash all held entries; drop this cycle's input
//  in_valid      in   1      upstream payload valid
//  in_ready      out  1      stage can accept; function of registered state only
//  in_data       in   WIDTH  upstream payload
//  out_valid     out  1      payload available downstream
//  out_ready     in   1      downstream accepts
//  out_data      out  WIDTH  head payload
//  stall_cycles  out  CNT_W  cycles with out_valid & !out_ready (PIPE_STAGE_PERF_EN only)
//  flush_count   out  CNT_W  number of flush cycles seen (PIPE_STAGE_PERF_EN only)
// BEHAVIOUR
//  - Storage: main entry (drives out_*) and skid entry; each has a valid bit.
//  - Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready.
//    - in_valid may rise without waiting for in_ready.
//    - in_data must be held stable while in_valid is high and in_ready is low.
//  - States (pipe_state_e): EMPTY (none valid), ONE (main only), FULL (main + skid).
//  - Outputs: out_valid = state != EMPTY; in_ready = state != FULL (never combinational).
//  - Transitions when flush = 0:
//    - EMPTY + accept        -> ONE; main <= in_data.
//    - ONE + accept + emit   -> ONE; main <= in_data.
//    - ONE + accept + !emit  -> FULL; skid <= in_data.
//    - ONE + !accept + emit  -> EMPTY.
//    - FULL + emit           -> ONE; main <= skid. No accept is possible in FULL.
//    - All other cases hold state.
//  - Latency: 1 cycle from accept to out_valid when EMPTY.
//  - Ordering: strict FIFO; no payload is ever duplicated or dropped (flush excepted).
//  - Flush has priority over every other event:
//    - Next state is EMPTY; main and skid data are set to RESET_VAL.
//    - Any accept in the flush cycle still completes the handshake, but its data is discarded.
//    - Any emit in the flush cycle is still valid: downstream has taken the head.
//  - Reset (rst_n = 0 at a clock edge), including mid-transfer:
//    - State EMPTY; both data entries RESET_VAL; perf counters 0.
//    - out_valid = 0, out_data = RESET_VAL, in_ready = 1 from the first post-reset cycle.
//    - Reset dominates flush.
//  - out_data does not change while out_valid & !out_ready (stable-under-backpressure).
// CONFIGURATION
//  - Macro PIPE_STAGE_PERF_EN defined:
//    - stall_cycles and flush_count ports exist.
//    - Counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
//    - Both counters are cleared only by reset.
//  - Macro not defined: the ports and counters are absent; the datapath is identical.
// STRUCTURE
//  - pipe_pkg: typedef enum logic [1:0] pipe_state_e {EMPTY, ONE, FULL}; CNT_W_DEFAULT = 32.
//  - Sub-module pipe_sat_cnt #(W): 1-bit increment, saturating, sync active-low reset.
//    - Instantiated twice, only under PIPE_STAGE_PERF_EN.
// TESTING
//  1. Reset with in_valid = 1, in_data = 0xA5:
//     -> out_valid = 0, out_data = RESET_VAL, in_ready = 1 one cycle after rst_n rises.
//  2. out_ready = 1; stream 0x1..0x8 back-to-back:
//     -> out emits 0x1..0x8 on consecutive cycles, first one 1 cycle after accept.
//  3. Send 0x11 then 0x22 with out_ready = 0:
//     -> FULL, in_ready = 0, out_data holds 0x11.
//     -> Raise out_ready: 0x11 then 0x22 emitted; in_ready returns to 1.
//  4. FULL (0x11, 0x22); pulse flush with in_valid = 1, in_data = 0x33:
//     -> next cycle out_valid = 0; 0x33 never appears on out_data.
//  5. Assert rst_n = 0 while FULL and out_ready toggling:
//     -> EMPTY next cycle; no stale payload emitted afterwards.
//  6. PIPE_STAGE_PERF_EN with CNT_W = 4: hold backpressure for 20 cycles, issue 3 flushes:
//     -> stall_cycles = 0xF (saturated), flush_count = 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: +1 per cycle with inc high, sticks at all-ones.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE_VAL = 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE_VAL;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer and flush.
// Optional stall/flush counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int                CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits for ready, and the source holds data while
  // valid is high and ready is low.
  pipe_state_e      state;
  pipe_state_e      state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !emit)      state_nxt = FULL;
          else if (!accept && emit) state_nxt = EMPTY;
        end
        FULL:    if (emit) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Both outputs decode registered state only, so ready never depends on
  // this cycle's downstream ready.
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: if (accept) main_data <= in_data;
        ONE: begin
          if (accept && emit)  main_data <= in_data;
          else if (accept)     skid_data <= in_data;
        end
        FULL:  if (emit) main_data <= skid_data;
        default: ;
      endcase
    end
  end

  assign out_data = main_data;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cycles)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_count)
  );
`else
  // CNT_W only sizes the counters; keep a reference so both builds share one parameter list.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table, handshake scoreboard,
// and (with PIPE_STAGE_PERF_EN) a counter saturation sequence.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int              WIDTH = 8;
  localparam logic [WIDTH-1:0] RV   = 8'h5A;
  localparam int              CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_stage_skid #(.WIDTH(WIDTH), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [WIDTH-1:0] id, input logic ordy);
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable at the falling edge, so the handshakes
  // that the next rising edge will complete are visible here.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL emit_unexpected: got %0h expected no transfer", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL emit_order: got %0h expected %0h", out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  typedef struct {
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_data;
    logic             chk_data;
  } vec_t;

  localparam int NV = 39;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [WIDTH-1:0] id, input logic ordy,
                              input logic ev, input logic er,
                              input logic [WIDTH-1:0] ed, input logic cd);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_ready = er; v.exp_data = ed; v.chk_data = cd;
    return v;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // reset with a pending input, then release
    vecs[0]  = mk(0, 0, 1, 8'hA5, 0,  0, 1, RV,    1);
    vecs[1]  = mk(0, 0, 1, 8'hA5, 1,  0, 1, RV,    1);
    vecs[2]  = mk(1, 0, 0, 8'h00, 1,  0, 1, RV,    1);
    // back-to-back stream
    for (int i = 1; i <= 8; i++)
      vecs[2+i] = mk(1, 0, 1, WIDTH'(i), 1,  1, 1, WIDTH'(i), 1);
    vecs[11] = mk(1, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0);
    // fill to FULL under backpressure, then drain
    vecs[12] = mk(1, 0, 1, 8'h11, 0,  1, 1, 8'h11, 1);
    vecs[13] = mk(1, 0, 1, 8'h22, 0,  1, 0, 8'h11, 1);
    vecs[14] = mk(1, 0, 0, 8'h00, 0,  1, 0, 8'h11, 1);
    vecs[15] = mk(1, 0, 0, 8'h00, 1,  1, 1, 8'h22, 1);
    vecs[16] = mk(1, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0);
    // flush while FULL with an offered 0x33
    vecs[17] = mk(1, 0, 1, 8'h11, 0,  1, 1, 8'h11, 1);
    vecs[18] = mk(1, 0, 1, 8'h22, 0,  1, 0, 8'h11, 1);
    vecs[19] = mk(1, 1, 1, 8'h33, 0,  0, 1, RV,    1);
    vecs[20] = mk(1, 0, 0, 8'h00, 0,  0, 1, RV,    1);
    // flush in ONE with accept and emit in the same cycle; flush in EMPTY
    vecs[21] = mk(1, 0, 1, 8'h44, 0,  1, 1, 8'h44, 1);
    vecs[22] = mk(1, 1, 1, 8'h33, 1,  0, 1, RV,    1);
    vecs[23] = mk(1, 1, 1, 8'h55, 0,  0, 1, RV,    1);
    vecs[24] = mk(1, 0, 0, 8'h00, 0,  0, 1, RV,    1);
    // input held while FULL: no accept until a slot frees
    vecs[25] = mk(1, 0, 1, 8'h66, 0,  1, 1, 8'h66, 1);
    vecs[26] = mk(1, 0, 1, 8'h77, 0,  1, 0, 8'h66, 1);
    vecs[27] = mk(1, 0, 1, 8'h88, 0,  1, 0, 8'h66, 1);
    vecs[28] = mk(1, 0, 1, 8'h88, 1,  1, 1, 8'h77, 1);
    vecs[29] = mk(1, 0, 1, 8'h88, 1,  1, 1, 8'h88, 1);
    vecs[30] = mk(1, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0);
    // reset while FULL with out_ready toggling; reset beats flush
    vecs[31] = mk(1, 0, 1, 8'hAA, 0,  1, 1, 8'hAA, 1);
    vecs[32] = mk(1, 0, 1, 8'hBB, 0,  1, 0, 8'hAA, 1);
    vecs[33] = mk(0, 0, 0, 8'h00, 1,  0, 1, RV,    1);
    vecs[34] = mk(0, 1, 0, 8'h00, 0,  0, 1, RV,    1);
    vecs[35] = mk(1, 0, 0, 8'h00, 1,  0, 1, RV,    1);
    vecs[36] = mk(1, 0, 0, 8'h00, 0,  0, 1, RV,    1);
    vecs[37] = mk(1, 0, 1, 8'hCC, 1,  1, 1, 8'hCC, 1);
    vecs[38] = mk(1, 0, 0, 8'h00, 1,  0, 1, 8'h00, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      tick();
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].chk_data)
        check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

`ifdef PIPE_STAGE_PERF_EN
    drive(0, 0, 0, '0, 0);
    tick();
    check("perf stall_after_reset", 32'(stall_cycles), 32'd0);
    check("perf flush_after_reset", 32'(flush_count), 32'd0);
    drive(1, 0, 1, 8'hD1, 0);
    tick();
    drive(1, 0, 0, '0, 0);
    repeat (5) tick();
    check("perf stall_5", 32'(stall_cycles), 32'd5);
    repeat (20) tick();
    check("perf stall_sat", 32'(stall_cycles), 32'hF);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, '0, 0);
      tick();
      drive(1, 0, 0, '0, 0);
      tick();
    end
    check("perf flush_count", 32'(flush_count), 32'd3);
    check("perf stall_hold", 32'(stall_cycles), 32'hF);
    check("perf out_valid", 32'(out_valid), 32'd0);
`endif

    tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
